// File: rtl/alib_rank_encoder.sv
// alib_rank_encoder
// Streams a byte packet through the rank table's query port and replaces each
// byte by its rank. Each rank becomes a short code (rank < 2^SHORT_BITS-1) or an
// escape code with the full rank above an all-ones nibble. Codes are packed
// LSB-first into WORD_BITS-bit words that leave over a valid/ready handshake.
module alib_rank_encoder #(
  parameter int WORD_BITS  = 32,
  parameter int SHORT_BITS = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [7:0]           i_data,
  input  logic                 i_valid,
  input  logic                 i_last,
  output logic                 o_ready,
  output logic [7:0]           o_query_char,
  input  logic                 i_rank_done,
  input  logic [7:0]           i_query_rank,
  output logic [WORD_BITS-1:0] o_word,
  output logic                 o_word_valid,
  output logic                 o_word_last,
  output logic [5:0]           o_word_bits,
  input  logic                 i_word_ready
);

  // An escape code carries the 8-bit rank above an all-ones short field.
  localparam int LONG_BITS = SHORT_BITS + 8;
  // One full word plus one worst-case code: a drain always makes room for an append.
  localparam int BUF_BITS  = WORD_BITS + LONG_BITS;
  localparam int CNT_W     = $clog2(BUF_BITS + 1);

  localparam logic [7:0]       ESC_RANK  = 8'((1 << SHORT_BITS) - 1);
  localparam logic [CNT_W-1:0] WORD_CNT  = CNT_W'(WORD_BITS);
  localparam logic [CNT_W:0]   BUF_CNT   = (CNT_W + 1)'(BUF_BITS);
  localparam logic [CNT_W-1:0] SHORT_LEN = CNT_W'(SHORT_BITS);
  localparam logic [CNT_W-1:0] LONG_LEN  = CNT_W'(LONG_BITS);

  typedef enum logic [2:0] {
    S_WAIT_TABLE,
    S_IDLE,
    S_QUERY,
    S_CAPTURE,
    S_PACK,
    S_FLUSH
  } state_e;

  state_e state_q, state_d;

  logic [7:0]           char_q;
  logic                 pkt_last_q;
  logic [7:0]           rank_q;
  logic [BUF_BITS-1:0]  buf_q, buf_d, buf_base;
  logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_base;

  logic [WORD_BITS-1:0] word_q;
  logic                 word_valid_q;
  logic                 word_last_q;
  logic [5:0]           word_bits_q;

  logic                 accept;
  logic                 short_code;
  logic [LONG_BITS-1:0] code_val;
  logic [CNT_W-1:0]     code_len;
  logic                 fits;
  logic                 do_append;
  logic                 word_free;
  logic                 flush_final;
  logic                 drain_full;
  logic                 drain_last;

  assign o_query_char = char_q;
  assign o_word       = word_q;
  assign o_word_valid = word_valid_q;
  assign o_word_last  = word_last_q;
  assign o_word_bits  = word_bits_q;

  assign accept = (state_q == S_IDLE) && i_valid;

  // Code for the captured rank: short field, or escape nibble with rank above it.
  assign short_code = (rank_q < ESC_RANK);
  assign code_val   = short_code ? LONG_BITS'(rank_q[SHORT_BITS-1:0])
                                 : {rank_q, {SHORT_BITS{1'b1}}};
  assign code_len   = short_code ? SHORT_LEN : LONG_LEN;

  // Room is judged on the pre-drain count so the stall rule does not depend
  // on downstream timing within the same cycle.
  assign fits      = ({1'b0, cnt_q} + {1'b0, code_len}) <= BUF_CNT;
  assign do_append = (state_q == S_PACK) && fits;

  // The output register takes a new word whenever it is empty or being emptied.
  // A count of exactly one word in FLUSH is the final word, not a full word
  // followed by an empty one.
  assign word_free   = !word_valid_q || i_word_ready;
  assign flush_final = (state_q == S_FLUSH) && (cnt_q != '0) && (cnt_q <= WORD_CNT);
  assign drain_full  = word_free && (cnt_q >= WORD_CNT) && !flush_final;
  assign drain_last  = word_free && flush_final;

  // Next buffer: drain from the bottom first, then append the new code above what remains.
  always_comb begin
    buf_base = buf_q;
    cnt_base = cnt_q;
    if (drain_full) begin
      buf_base = buf_q >> WORD_BITS;
      cnt_base = cnt_q - WORD_CNT;
    end else if (drain_last) begin
      buf_base = '0;
      cnt_base = '0;
    end
    buf_d = buf_base;
    cnt_d = cnt_base;
    if (do_append) begin
      buf_d = buf_base | (BUF_BITS'(code_val) << cnt_base);
      cnt_d = cnt_base + code_len;
    end
  end

  // Next-state and handshake decode for the byte-side FSM.
  always_comb begin
    state_d = state_q;
    o_ready = 1'b0;
    case (state_q)
      S_WAIT_TABLE: if (i_rank_done) state_d = S_IDLE;
      S_IDLE: begin
        o_ready = 1'b1;
        if (i_valid) state_d = S_QUERY;
      end
      // One cycle for the table's registered lookup to settle.
      S_QUERY:   state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_PACK;
      S_PACK: begin
        if (do_append) state_d = pkt_last_q ? S_FLUSH : S_IDLE;
      end
      S_FLUSH: begin
        if (word_valid_q && word_last_q && i_word_ready) state_d = S_WAIT_TABLE;
      end
      default: state_d = S_WAIT_TABLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state_q <= S_WAIT_TABLE;
    else        state_q <= state_d;
  end

  // Query character and last flag are only ever loaded on a byte accept.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      char_q     <= '0;
      pkt_last_q <= 1'b0;
    end else if (accept) begin
      char_q     <= i_data;
      pkt_last_q <= i_last;
    end
  end

  // Capture the table's answer once its latency has elapsed.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)                    rank_q <= '0;
    else if (state_q == S_CAPTURE) rank_q <= i_query_rank;
  end

  // Bit buffer and fill count.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      buf_q <= '0;
      cnt_q <= '0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
    end
  end

  // Output word register: holds its contents until accepted downstream.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      word_q       <= '0;
      word_valid_q <= 1'b0;
      word_last_q  <= 1'b0;
      word_bits_q  <= '0;
    end else if (drain_full || drain_last) begin
      word_q       <= buf_q[WORD_BITS-1:0];
      word_valid_q <= 1'b1;
      word_last_q  <= drain_last;
      word_bits_q  <= drain_full ? 6'(WORD_BITS) : 6'(cnt_q);
    end else if (i_word_ready) begin
      word_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alib_rank_encoder.sv
// Bench for alib_rank_encoder: a rank table model answers queries with one
// cycle of latency; expected words come from a bit-queue model of the code stream.
module tb_alib_rank_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  din;
  logic        vin;
  logic        lin;
  logic        rdy;
  logic [7:0]  qchar;
  logic        rdone;
  logic [7:0]  qrank;
  logic [31:0] w;
  logic        wv;
  logic        wl;
  logic [5:0]  wb;
  logic        wr_rdy;

  int n_vec = 0;
  int n_err = 0;
  int n_acc = 0;
  int bp_mode = 0;   // 0: always ready, 1: random, 2: held low

  logic [7:0]  rank_tbl [256];
  logic [7:0]  pkt [$];
  logic [31:0] exp_w [$];
  int          exp_b [$];
  bit          exp_l [$];
  logic [31:0] got_w [$];
  int          got_b [$];
  bit          got_l [$];

  always #5 clk = ~clk;

  alib_rank_encoder #(.WORD_BITS(32), .SHORT_BITS(4)) dut (
    .i_clk(clk), .i_rst(rst_n), .i_data(din), .i_valid(vin), .i_last(lin),
    .o_ready(rdy), .o_query_char(qchar), .i_rank_done(rdone), .i_query_rank(qrank),
    .o_word(w), .o_word_valid(wv), .o_word_last(wl), .o_word_bits(wb),
    .i_word_ready(wr_rdy)
  );

  // Rank table: registered lookup, one cycle latency.
  always @(posedge clk) qrank <= rank_tbl[qchar];

  // Record every word transfer and byte accept that the next edge will complete.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && wv && wr_rdy) begin
      got_w.push_back(w);
      got_b.push_back(int'(wb));
      got_l.push_back(wl);
    end
    if (rst_n === 1'b1 && vin && rdy) n_acc <= n_acc + 1;
  end

  // Downstream ready generator.
  initial begin
    wr_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (bp_mode)
        0:       wr_rdy = 1'b1;
        1:       wr_rdy = 1'($urandom_range(0, 1));
        default: wr_rdy = 1'b0;
      endcase
    end
  end

  // Model: concatenate codes LSB-first as a bit stream, then cut into 32-bit words.
  task automatic build_expected();
    bit          bq [$];
    logic [7:0]  r;
    logic [31:0] acc;
    int          n;
    exp_w.delete(); exp_b.delete(); exp_l.delete();
    foreach (pkt[i]) begin
      r = rank_tbl[pkt[i]];
      if (r < 8'd15) begin
        for (int k = 0; k < 4; k++) bq.push_back(r[k]);
      end else begin
        for (int k = 0; k < 4; k++) bq.push_back(1'b1);
        for (int k = 0; k < 8; k++) bq.push_back(r[k]);
      end
    end
    while (bq.size() > 0) begin
      n = (bq.size() > 32) ? 32 : bq.size();
      acc = '0;
      for (int k = 0; k < n; k++) acc[k] = bq.pop_front();
      exp_w.push_back(acc);
      exp_b.push_back(n);
      exp_l.push_back(bq.size() == 0);
    end
  endtask

  task automatic send_pkt(input bit mark_last);
    int cyc;
    foreach (pkt[i]) begin
      din = pkt[i];
      lin = mark_last && (i == pkt.size() - 1);
      vin = 1'b1;
      cyc = 0;
      @(negedge clk);
      while (!rdy && cyc < 400) begin
        @(negedge clk);
        cyc++;
      end
      if (!rdy) begin
        n_vec++; n_err++;
        $display("FAIL accept_timeout byte%0d: o_ready=%b, required 1", i, rdy);
        vin = 1'b0; lin = 1'b0;
        return;
      end
      @(posedge clk); #1;
      vin = 1'b0; lin = 1'b0;
    end
  endtask

  task automatic wait_last(input int base, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (got_l.size() > base && got_l[got_l.size()-1]) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 256; i++) rank_tbl[i] = 8'd0;
    rst_n = 1'b0; vin = 1'b0; lin = 1'b0; din = 8'h00; rdone = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (rdy !== 1'b0)     begin n_err++; $display("FAIL rst_ready: got %b, required 0", rdy); end
    n_vec++; if (qchar !== 8'h00)  begin n_err++; $display("FAIL rst_qchar: got %h, required 00", qchar); end
    n_vec++; if (w !== 32'h0)      begin n_err++; $display("FAIL rst_word: got %h, required 0", w); end
    n_vec++; if (wv !== 1'b0)      begin n_err++; $display("FAIL rst_wvalid: got %b, required 0", wv); end
    n_vec++; if (wl !== 1'b0)      begin n_err++; $display("FAIL rst_wlast: got %b, required 0", wl); end
    n_vec++; if (wb !== 6'd0)      begin n_err++; $display("FAIL rst_wbits: got %0d, required 0", wb); end
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++; if (rdy !== 1'b0)     begin n_err++; $display("FAIL rst_wait_ready: got %b, required 0", rdy); end
  endtask

  task automatic test_spec_packets();
    logic [31:0] spec_w0 [3] = '{32'h000014F0, 32'h11111111, 32'h8FC8FC8F};
    int          spec_n  [3] = '{1, 1, 2};
    int base;
    bit ok;
    rdone = 1'b1;
    rank_tbl[8'h41] = 8'd0;  rank_tbl[8'h42] = 8'd20;
    rank_tbl[8'h11] = 8'd1;  rank_tbl[8'hC8] = 8'd200;
    for (int t = 0; t < 3; t++) begin
      pkt.delete();
      case (t)
        0:       begin pkt.push_back(8'h41); pkt.push_back(8'h42); end
        1:       repeat (8) pkt.push_back(8'h11);
        default: repeat (3) pkt.push_back(8'hC8);
      endcase
      base = got_w.size();
      build_expected();
      send_pkt(1'b1);
      wait_last(base, ok);
      n_vec++; if (!ok) begin n_err++; $display("FAIL spec%0d_done: last word not seen", t); end
      n_vec++;
      if (got_w.size() - base != spec_n[t]) begin
        n_err++; $display("FAIL spec%0d_count: got %0d words, required %0d", t, got_w.size() - base, spec_n[t]);
      end
      n_vec++;
      if (got_w.size() <= base || got_w[base] !== spec_w0[t]) begin
        n_err++; $display("FAIL spec%0d_word0: got %h, required %h", t, (got_w.size() > base) ? got_w[base] : 32'hx, spec_w0[t]);
      end
      foreach (exp_w[i]) if (base + i < got_w.size()) begin
        n_vec++;
        if (got_w[base+i] !== exp_w[i] || got_b[base+i] != exp_b[i] || got_l[base+i] != exp_l[i]) begin
          n_err++;
          $display("FAIL spec%0d_w%0d: got %h/%0d/%0d, required %h/%0d/%0d", t, i,
                   got_w[base+i], got_b[base+i], got_l[base+i], exp_w[i], exp_b[i], exp_l[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int base;
    int acc0;
    bit ok;
    rank_tbl[8'h33] = 8'd3;
    // Twelve bytes: the first word waits in the register, the rest waits in the buffer.
    pkt.delete();
    repeat (12) pkt.push_back(8'h33);
    base = got_w.size();
    build_expected();
    bp_mode = 2;
    send_pkt(1'b1);
    repeat (20) begin
      @(negedge clk);
      n_vec++;
      if (wv !== 1'b1 || w !== exp_w[0] || rdy !== 1'b0) begin
        n_err++; $display("FAIL bp_hold: valid=%b word=%h ready=%b, required 1/%h/0", wv, w, rdy, exp_w[0]);
      end
    end
    bp_mode = 0;
    wait_last(base, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL bp_done: last word not seen"); end
    n_vec++; if (got_w.size() - base != exp_w.size()) begin
      n_err++; $display("FAIL bp_count: got %0d words, required %0d", got_w.size() - base, exp_w.size());
    end
    foreach (exp_w[i]) if (base + i < got_w.size()) begin
      n_vec++;
      if (got_w[base+i] !== exp_w[i] || got_b[base+i] != exp_b[i] || got_l[base+i] != exp_l[i]) begin
        n_err++;
        $display("FAIL bp_w%0d: got %h/%0d/%0d, required %h/%0d/%0d", i,
                 got_w[base+i], got_b[base+i], got_l[base+i], exp_w[i], exp_b[i], exp_l[i]);
      end
    end
    // Twenty-four bytes: register holds 8, buffer fills with 11, the 20th stalls in PACK.
    pkt.delete();
    repeat (24) pkt.push_back(8'h33);
    base = got_w.size();
    build_expected();
    acc0 = n_acc;
    bp_mode = 2;
    fork
      send_pkt(1'b1);
      begin
        repeat (150) @(negedge clk);
        n_vec++;
        if (n_acc - acc0 != 20 || rdy !== 1'b0) begin
          n_err++; $display("FAIL stall: accepted %0d ready=%b, required 20/0", n_acc - acc0, rdy);
        end
        bp_mode = 0;
      end
    join
    wait_last(base, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL stall_done: last word not seen"); end
    n_vec++; if (got_w.size() - base != exp_w.size()) begin
      n_err++; $display("FAIL stall_count: got %0d words, required %0d", got_w.size() - base, exp_w.size());
    end
    foreach (exp_w[i]) if (base + i < got_w.size()) begin
      n_vec++;
      if (got_w[base+i] !== exp_w[i] || got_b[base+i] != exp_b[i] || got_l[base+i] != exp_l[i]) begin
        n_err++;
        $display("FAIL stall_w%0d: got %h/%0d/%0d, required %h/%0d/%0d", i,
                 got_w[base+i], got_b[base+i], got_l[base+i], exp_w[i], exp_b[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_rank_done();
    int base;
    bit ok;
    // Drop rank_done mid-packet: the packet still completes normally.
    pkt.delete();
    pkt.push_back(8'h41); pkt.push_back(8'h42); pkt.push_back(8'h11);
    base = got_w.size();
    build_expected();
    fork
      send_pkt(1'b1);
      begin repeat (6) @(posedge clk); #1; rdone = 1'b0; end
    join
    wait_last(base, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL rd_mid_done: last word not seen"); end
    foreach (exp_w[i]) begin
      n_vec++;
      if (base + i >= got_w.size() || got_w[base+i] !== exp_w[i] || got_b[base+i] != exp_b[i] || got_l[base+i] != exp_l[i]) begin
        n_err++; $display("FAIL rd_mid_w%0d: word missing or wrong, required %h/%0d/%0d", i, exp_w[i], exp_b[i], exp_l[i]);
      end
    end
    // Now parked waiting for the table: offered byte must not be taken.
    rank_tbl[8'h77] = 8'd15;   // smallest escaped rank
    pkt.delete();
    pkt.push_back(8'h77);
    base = got_w.size();
    build_expected();
    din = 8'h77; lin = 1'b1; vin = 1'b1;
    repeat (10) begin
      @(negedge clk);
      n_vec++;
      if (rdy !== 1'b0 || qchar !== 8'h11) begin
        n_err++; $display("FAIL rd_wait: ready=%b qchar=%h, required 0/11", rdy, qchar);
      end
    end
    @(posedge clk); #1;
    rdone = 1'b1;
    @(negedge clk);
    n_vec++; if (rdy !== 1'b0) begin n_err++; $display("FAIL rd_rise0: ready=%b, required 0", rdy); end
    @(negedge clk);
    n_vec++; if (rdy !== 1'b1) begin n_err++; $display("FAIL rd_rise1: ready=%b, required 1", rdy); end
    @(posedge clk); #1;
    vin = 1'b0; lin = 1'b0;
    wait_last(base, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL rd_esc_done: last word not seen"); end
    n_vec++;
    if (got_w.size() <= base || got_w[base] !== exp_w[0] || got_b[base] != exp_b[0] || got_l[base] != 1'b1) begin
      n_err++; $display("FAIL rd_esc_w0: word missing or wrong, required %h/%0d/1", exp_w[0], exp_b[0]);
    end
  endtask

  task automatic test_midreset();
    int base;
    bit ok;
    pkt.delete();
    repeat (6) pkt.push_back(8'h33);
    base = got_w.size();
    send_pkt(1'b0);
    @(posedge clk);          // to CAPTURE
    @(posedge clk);          // to PACK of the 6th byte, 20 bits buffered
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (wv !== 1'b0 || w !== 32'h0 || wb !== 6'd0 || wl !== 1'b0 || rdy !== 1'b0) begin
      n_err++; $display("FAIL mr_outputs: valid=%b word=%h bits=%0d last=%b ready=%b, required all 0", wv, w, wb, wl, rdy);
    end
    n_vec++; if (got_w.size() != base) begin
      n_err++; $display("FAIL mr_partial: %0d words emitted, required 0", got_w.size() - base);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++; if (rdy !== 1'b0) begin n_err++; $display("FAIL mr_wait: ready=%b, required 0", rdy); end
    pkt.delete();
    pkt.push_back(8'h41); pkt.push_back(8'h42);
    base = got_w.size();
    build_expected();
    send_pkt(1'b1);
    wait_last(base, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL mr_done: last word not seen"); end
    n_vec++;
    if (got_w.size() - base != 1 || got_w[base] !== exp_w[0] || got_b[base] != exp_b[0] || got_l[base] != 1'b1) begin
      n_err++; $display("FAIL mr_clean: got %0d words first=%h, required 1 word %h/%0d",
                        got_w.size() - base, (got_w.size() > base) ? got_w[base] : 32'hx, exp_w[0], exp_b[0]);
    end
  endtask

  task automatic test_random();
    int base;
    int len;
    bit ok;
    for (int i = 0; i < 256; i++)
      rank_tbl[i] = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(15, 255)) : 8'($urandom_range(0, 14));
    bp_mode = 1;
    for (int p = 0; p < 40; p++) begin
      pkt.delete();
      len = $urandom_range(1, 20);
      repeat (len) pkt.push_back(8'($urandom_range(0, 255)));
      base = got_w.size();
      build_expected();
      send_pkt(1'b1);
      wait_last(base, ok);
      n_vec++; if (!ok) begin n_err++; $display("FAIL rnd%0d_done: last word not seen", p); end
      n_vec++; if (got_w.size() - base != exp_w.size()) begin
        n_err++; $display("FAIL rnd%0d_count: got %0d words, required %0d", p, got_w.size() - base, exp_w.size());
      end
      foreach (exp_w[i]) if (base + i < got_w.size()) begin
        n_vec++;
        if (got_w[base+i] !== exp_w[i] || got_b[base+i] != exp_b[i] || got_l[base+i] != exp_l[i]) begin
          n_err++;
          $display("FAIL rnd%0d_w%0d: got %h/%0d/%0d, required %h/%0d/%0d", p, i,
                   got_w[base+i], got_b[base+i], got_l[base+i], exp_w[i], exp_b[i], exp_l[i]);
        end
      end
    end
    bp_mode = 0;
  endtask

  initial begin
    test_reset();
    test_spec_packets();
    test_backpressure();
    test_rank_done();
    test_midreset();
    test_random();
    repeat (4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
